os_step_sequencer: RTL and testbench
====================================

# os_step_sequencer

Operand sequencer that sits directly upstream of the output-stationary systolic array. It holds one A tile (M×K) and one B tile (K×N) of FP32 bit patterns, loaded through a word-write port. On `start` it issues K array steps over the array's step handshake, presenting column k of A and row k of B with `k_first`/`k_last` tags. It then waits for the array's result-valid pulse and reports `done`.

## Interface
- M, 8, array rows (A column length)
- N, 8, array columns (B row length)
- K_MAX, 16, maximum reduction depth held in the banks
- IW, $clog2(M>N?M:N), width of `wr_idx`
- KW, $clog2(K_MAX), width of `wr_k`

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wr_en  in  1  operand write strobe
- wr_sel  in  1  0 = A bank, 1 = B bank
- wr_k  in  KW  k index of the written word
- wr_idx  in  IW  row (A) or column (B) index
- wr_data  in  32  FP32 bit pattern
- start  in  1  begin a K-step sequence (pulse)
- k_len  in  $clog2(K_MAX+1)  steps to issue; sampled on `start`
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the result has been observed
- err  out  1  one-cycle pulse when `start` is rejected
- step_valid  out  1  step offered to the array
- step_ready  in  1  array can accept a step
- a_row_flat  out  M*32  A[i][k] at bits i*32 +: 32
- b_col_flat  out  N*32  B[k][j] at bits j*32 +: 32
- k_first  out  1  current step is k = 0
- k_last  out  1  current step is k = k_len−1
- c_valid_in  in  1  OR-reduction of the array's per-PE result-valid pulses

## Operation
- Write port:
  - With `wr_en` and `wr_sel=0`, write A[wr_idx][wr_k].
  - With `wr_en` and `wr_sel=1`, write B[wr_k][wr_idx].
  - Out-of-range indices (A: `wr_idx ≥ M`; B: `wr_idx ≥ N`; `wr_k ≥ K_MAX`) are dropped.
  - Writes while `busy`=1 are dropped, so banks stay stable during a sequence.
- FSM has four states: S_IDLE, S_ISSUE, S_DRAIN, S_DONE.
- S_IDLE, on `start`:
  - If `k_len` is 0 or greater than K_MAX: pulse `err`, stay in S_IDLE.
  - Otherwise: latch `k_len`, clear `k_cnt` to 0, go to S_ISSUE.
- S_ISSUE:
  - `step_valid`=1.
  - `a_row_flat` and `b_col_flat` are driven from the banks at `k_cnt`.
  - `k_first` = (`k_cnt`==0); `k_last` = (`k_cnt`==`k_len_lat`−1).
  - A step is accepted when `step_valid` && `step_ready`.
  - On accept with `k_last` set: go to S_DRAIN. On accept otherwise: `k_cnt`++.
- S_DRAIN: `step_valid`=0. Wait for `c_valid_in`, then go to S_DONE.
- S_DONE: `done`=1 for one cycle, then go to S_IDLE.
- `busy` = (state ≠ S_IDLE).
- `k_first`, `k_last`, `a_row_flat` and `b_col_flat` read 0 whenever `step_valid`=0.
- Ignored events:
  - `start` while `busy`=1.
  - `c_valid_in` outside S_DRAIN.
  - A write and `start` in the same cycle in S_IDLE: the write lands and `start` proceeds. The first step presents the new word.
- Reset mid-operation: state returns to S_IDLE, `k_cnt` to 0, both banks cleared to 0. No partial step is replayed.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `step_valid`=0, `k_first`=0, `k_last`=0, `a_row_flat`=0, `b_col_flat`=0.
- Step outputs are combinational from state, `k_cnt` and the bank registers. No combinational path from `step_ready` to any output.
- `start` accepted in cycle t → `step_valid` high from cycle t+1.
- `step_valid` and the step payload are held unchanged until accepted.
- After an accept in cycle t:
  - The next step is offered in cycle t+1.
  - When the array's ready is low, the sequencer simply waits; no bubble is added by the sequencer.
- `k_len`=1: the single step carries `k_first`=`k_last`=1.
- `c_valid_in` in cycle t during S_DRAIN → `done` in cycle t+1 → `busy`=0 in cycle t+2.
- Best-case total, `start` to `done`: k_len + array latency + 2 cycles.

## Structure
- Shared package `tpu_os_pkg`:
  - `FP32_W`=32.
  - `seq_state_t` enum (S_IDLE, S_ISSUE, S_DRAIN, S_DONE).
  - `fp32_t` typedef.
- One sub-module, `os_operand_bank` (params ROWS, K_MAX):
  - Register array with a write port and a full-vector read at index k.
  - Instantiated as the A bank (ROWS=M) and the B bank (ROWS=N).
  - The top holds only the FSM, `k_cnt`, `k_len` latch and the handshake.

## Test plan
1. **Single step, k_len=1.** Load A[i][0]=0x3F800000 and B[0][j]=0x40000000; hold `step_ready`=1; pulse `start` → one `step_valid` cycle with `k_first`=`k_last`=1 and the loaded words in place. Drive `c_valid_in` 5 cycles later → `done` one cycle later.
2. **Full depth with backpressure, k_len=4.** Stall with `step_ready` low for 3 cycles after each accept → exactly 4 accepts. `k_cnt` order is 0,1,2,3; `k_first` only on the first, `k_last` only on the fourth; payload stable during every stall.
3. **Bad k_len.** `start` with `k_len`=0, then with K_MAX+1 → `err` pulses each time; `busy` stays 0; `step_valid` never rises.
4. **Writes and start while busy.** Write A[0][0]=0xDEADBEEF and pulse `start` mid-sequence → bank unchanged, sequence unaffected. The next run presents the old value.
5. **Reset mid-sequence.** Assert `rst` during S_ISSUE at k=2 → all outputs 0 the next cycle; a new run issues zeros until the banks are reloaded.
6. **End-to-end with the array.** M=N=2, K=3, identity-scaled operands → the array's `c_out_flat` matches the FP32 golden matmul; `done` follows the array's result-valid pulse by one cycle.

Source files
------------

// File: rtl/tpu_os_pkg.sv
// Shared definitions for the output-stationary array front end.
//   FP32_W      : width of one FP32 bit pattern
//   fp32_t      : FP32 bit-pattern type
//   seq_state_t : step-sequencer FSM states
package tpu_os_pkg;

    localparam int FP32_W = 32;

    typedef logic [FP32_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/os_operand_bank.sv
// Operand bank: K_MAX x ROWS words of FP32, one word-write port and a
// full-vector read of every row at a single k index.
//   clk, rst   : clock, synchronous active-high reset (clears all words)
//   i_wr_en    : write strobe
//   i_wr_k     : k index of written word (>= K_MAX matches no word, dropped)
//   i_wr_idx   : row index of written word (>= ROWS matches no word, dropped)
//   i_wr_data  : FP32 word
//   i_rd_k     : k index to read
//   o_rd_flat  : word for row r at bits r*FP32_W +: FP32_W
module os_operand_bank
    import tpu_os_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int K_MAX = 16,
    parameter int IW    = $clog2(ROWS),
    parameter int KW    = $clog2(K_MAX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [KW-1:0]          i_wr_k,
    input  logic [IW-1:0]          i_wr_idx,
    input  fp32_t                  i_wr_data,
    input  logic [KW-1:0]          i_rd_k,
    output logic [ROWS*FP32_W-1:0] o_rd_flat
);

    fp32_t [K_MAX-1:0][ROWS-1:0] w_words;

    // One register per word with its own address match: indices outside the
    // populated range simply match nothing, which drops the write.
    for (genvar gk = 0; gk < K_MAX; gk++) begin : g_k
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            fp32_t r_word;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_word <= '0;
                end else if (i_wr_en && (i_wr_k == KW'(gk)) && (i_wr_idx == IW'(gi))) begin
                    r_word <= i_wr_data;
                end
            end

            assign w_words[gk][gi] = r_word;
        end
    end

    assign o_rd_flat = w_words[i_rd_k];

endmodule

// File: rtl/os_step_sequencer.sv
// Operand sequencer upstream of the output-stationary systolic array. Holds
// one A tile (M x K) and one B tile (K x N), issues k_len steps over a
// valid/ready handshake, then waits for the array's result-valid pulse.
//   clk, rst           : clock, synchronous active-high reset
//   wr_en/wr_sel/wr_k/wr_idx/wr_data : operand word write (sel 0 = A, 1 = B)
//   start, k_len       : begin a sequence of k_len steps
//   busy, done, err    : status; done/err are one-cycle pulses
//   step_valid/step_ready : step handshake to the array
//   a_row_flat         : A[i][k] at bits i*32 +: 32
//   b_col_flat         : B[k][j] at bits j*32 +: 32
//   k_first, k_last    : step position tags
//   c_valid_in         : OR of the array's result-valid pulses
module os_step_sequencer
    import tpu_os_pkg::*;
#(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int K_MAX = 16,
    parameter int IW    = $clog2(M > N ? M : N),
    parameter int KW    = $clog2(K_MAX),
    parameter int KLW   = $clog2(K_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [KW-1:0]       wr_k,
    input  logic [IW-1:0]       wr_idx,
    input  logic [31:0]         wr_data,
    input  logic                start,
    input  logic [KLW-1:0]      k_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                step_valid,
    input  logic                step_ready,
    output logic [M*FP32_W-1:0] a_row_flat,
    output logic [N*FP32_W-1:0] b_col_flat,
    output logic                k_first,
    output logic                k_last,
    input  logic                c_valid_in
);

    seq_state_t      r_state;
    logic [KW-1:0]   r_k_cnt;
    logic [KLW-1:0]  r_k_len;
    logic            r_err;

    logic            w_issue;
    logic            w_accept;
    logic            w_at_last;
    logic            w_start_ok;
    logic            w_bank_we;
    logic [M*FP32_W-1:0] w_a_flat;
    logic [N*FP32_W-1:0] w_b_flat;

    // Banks are frozen for the whole sequence, so writes only land in idle.
    assign w_bank_we = wr_en && (r_state == S_IDLE);

    os_operand_bank #(
        .ROWS  (M),
        .K_MAX (K_MAX),
        .IW    (IW),
        .KW    (KW)
    ) u_bank_a (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_bank_we && !wr_sel),
        .i_wr_k    (wr_k),
        .i_wr_idx  (wr_idx),
        .i_wr_data (wr_data),
        .i_rd_k    (r_k_cnt),
        .o_rd_flat (w_a_flat)
    );

    os_operand_bank #(
        .ROWS  (N),
        .K_MAX (K_MAX),
        .IW    (IW),
        .KW    (KW)
    ) u_bank_b (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_bank_we && wr_sel),
        .i_wr_k    (wr_k),
        .i_wr_idx  (wr_idx),
        .i_wr_data (wr_data),
        .i_rd_k    (r_k_cnt),
        .o_rd_flat (w_b_flat)
    );

    assign w_issue    = (r_state == S_ISSUE);
    assign w_accept   = w_issue && step_ready;
    assign w_at_last  = (32'(r_k_cnt) + 32'd1) == 32'(r_k_len);
    assign w_start_ok = (k_len != '0) && (32'(k_len) <= K_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k_cnt <= '0;
            r_k_len <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_k_len <= k_len;
                            r_k_cnt <= '0;
                            r_state <= S_ISSUE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        if (w_at_last) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_k_cnt <= r_k_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (c_valid_in) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Step payload and tags depend only on state, k_cnt and the banks, so
    // step_ready never reaches an output combinationally.
    assign step_valid = w_issue;
    assign k_first    = w_issue && (r_k_cnt == '0);
    assign k_last     = w_issue && w_at_last;
    assign a_row_flat = w_issue ? w_a_flat : '0;
    assign b_col_flat = w_issue ? w_b_flat : '0;

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign err  = r_err;

endmodule

// File: tb/tb_os_step_sequencer.sv
// Scoreboard bench for os_step_sequencer. The stimulus process keeps a plain
// array model of both operand tiles and, on each start, queues the expected
// steps, done cycle or err cycle; a negedge monitor pops and compares.
module tb_os_step_sequencer;

    localparam int TM     = 6;
    localparam int TN     = 5;
    localparam int TK     = 12;
    localparam int TIW    = $clog2(TM > TN ? TM : TN);
    localparam int TKW    = $clog2(TK);
    localparam int TKLW   = $clog2(TK + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wr_en = 1'b0;
    logic               wr_sel = 1'b0;
    logic [TKW-1:0]     wr_k = '0;
    logic [TIW-1:0]     wr_idx = '0;
    logic [31:0]        wr_data = '0;
    logic               start = 1'b0;
    logic [TKLW-1:0]    k_len = '0;
    logic               busy, done, err, step_valid;
    logic               step_ready = 1'b0;
    logic [TM*32-1:0]   a_row_flat;
    logic [TN*32-1:0]   b_col_flat;
    logic               k_first, k_last;
    logic               c_valid_in = 1'b0;

    os_step_sequencer #(
        .M     (TM),
        .N     (TN),
        .K_MAX (TK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_k       (wr_k),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .a_row_flat (a_row_flat),
        .b_col_flat (b_col_flat),
        .k_first    (k_first),
        .k_last     (k_last),
        .c_valid_in (c_valid_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TM*32-1:0] a;
        logic [TN*32-1:0] b;
        logic             first;
        logic             last;
    } step_t;

    logic [31:0] mA [TK][TM];
    logic [31:0] mB [TK][TN];

    step_t exp_q[$];
    int    done_q[$];
    int    err_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accepts  = 0;
    int ready_mode = 0;
    int stall    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [TM*32-1:0] model_a(input int k);
        logic [TM*32-1:0] r;
        for (int i = 0; i < TM; i++) r[i*32 +: 32] = mA[k][i];
        return r;
    endfunction

    function automatic logic [TN*32-1:0] model_b(input int k);
        logic [TN*32-1:0] r;
        for (int j = 0; j < TN; j++) r[j*32 +: 32] = mB[k][j];
        return r;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < TK; k++) begin
            for (int i = 0; i < TM; i++) mA[k][i] = '0;
            for (int j = 0; j < TN; j++) mB[k][j] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one write for the coming edge; the model takes it only when
    // the sequencer is known idle and the indices are in range.
    task automatic drive_write(input bit sel, input int k, input int idx, input logic [31:0] d,
                               input bit lands);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_k    = TKW'(k);
        wr_idx  = TIW'(idx);
        wr_data = d;
        if (lands && k < TK) begin
            if (!sel && idx < TM) mA[k][idx] = d;
            if (sel && idx < TN)  mB[k][idx] = d;
        end
    endtask

    task automatic idle_write(input bit sel, input int k, input int idx, input logic [31:0] d);
        drive_write(sel, k, idx, d, 1'b1);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_run(input int klen, input int mode, input bit same_cycle_write,
                          input int drain_delay);
        int acc0;
        int budget;
        step_t s;
        ready_mode = mode;
        if (same_cycle_write)
            drive_write($urandom_range(0, 1), $urandom_range(0, klen - 1),
                        $urandom_range(0, 4), $urandom, 1'b1);
        start = 1'b1;
        k_len = TKLW'(klen);
        for (int k = 0; k < klen; k++) begin
            s.a = model_a(k);
            s.b = model_b(k);
            s.first = (k == 0);
            s.last  = (k == klen - 1);
            exp_q.push_back(s);
        end
        acc0 = accepts;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_after_start", 256'(busy), 256'(1));
        check("valid_after_start", 256'(step_valid), 256'(1));
        budget = 0;
        // While steps are outstanding the sequencer is busy: writes, starts
        // and result-valid pulses issued here must all be ignored.
        while (exp_q.size() > 0 && budget < 2000) begin
            if ($urandom_range(0, 3) == 0)
                drive_write($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 7),
                            32'hDEADBEEF, 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                start = 1'b1;
                k_len = TKLW'($urandom_range(0, 15));
            end
            c_valid_in = ($urandom_range(0, 5) == 0);
            tick();
            wr_en = 1'b0;
            start = 1'b0;
            c_valid_in = 1'b0;
            budget++;
        end
        if (budget >= 2000) begin
            check("step_timeout", 256'(0), 256'(1));
            exp_q.delete();
        end
        check("accept_count", 256'(accepts - acc0), 256'(klen));
        for (int d = 0; d < drain_delay; d++) tick();
        check("busy_in_drain", 256'(busy), 256'(1));
        check("valid_in_drain", 256'(step_valid), 256'(0));
        c_valid_in = 1'b1;
        done_q.push_back(cyc + 1);
        tick();
        c_valid_in = 1'b0;
        tick();
        check("busy_after_done", 256'(busy), 256'(0));
    endtask

    task automatic bad_start(input int klen);
        start = 1'b1;
        k_len = TKLW'(klen);
        err_q.push_back(cyc + 1);
        tick();
        start = 1'b0;
        check("bad_busy", 256'(busy), 256'(0));
        check("bad_valid", 256'(step_valid), 256'(0));
        tick();
        check("bad_busy_later", 256'(busy), 256'(0));
    endtask

    // Step-ready generator: always ready, random, or three stall cycles
    // after every accept.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: step_ready = 1'b1;
                1: step_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (stall > 0) begin
                        step_ready = 1'b0;
                        stall--;
                    end else begin
                        step_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (step_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_step", 256'(1), 256'(0));
                end else begin
                    check("step_a", 256'(a_row_flat), 256'(exp_q[0].a));
                    check("step_b", 256'(b_col_flat), 256'(exp_q[0].b));
                    check("k_first", 256'(k_first), 256'(exp_q[0].first));
                    check("k_last", 256'(k_last), 256'(exp_q[0].last));
                    if (step_ready) begin
                        void'(exp_q.pop_front());
                        accepts++;
                        if (ready_mode == 2) stall = 3;
                    end
                end
            end else begin
                check("idle_a_zero", 256'(a_row_flat), 256'(0));
                check("idle_b_zero", 256'(b_col_flat), 256'(0));
                check("idle_tags_zero", 256'({k_first, k_last}), 256'(0));
            end
            if (done) begin
                if (done_q.size() > 0) begin
                    check("done_cycle", 256'(cyc), 256'(done_q[0]));
                    void'(done_q.pop_front());
                end else begin
                    check("done_spurious", 256'(1), 256'(0));
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                check("done_missing", 256'(0), 256'(1));
                void'(done_q.pop_front());
            end
            if (err) begin
                if (err_q.size() > 0) begin
                    check("err_cycle", 256'(cyc), 256'(err_q[0]));
                    void'(err_q.pop_front());
                end else begin
                    check("err_spurious", 256'(1), 256'(0));
                end
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                check("err_missing", 256'(0), 256'(1));
                void'(err_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        rst = 1'b1;
        repeat (4) tick();
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_valid", 256'(step_valid), 256'(0));
        check("rst_tags", 256'({k_first, k_last}), 256'(0));
        check("rst_a", 256'(a_row_flat), 256'(0));
        check("rst_b", 256'(b_col_flat), 256'(0));
        rst = 1'b0;
        tick();

        // Single step with known constants.
        for (int i = 0; i < TM; i++) idle_write(1'b0, 0, i, 32'h3F800000);
        for (int j = 0; j < TN; j++) idle_write(1'b1, 0, j, 32'h40000000);
        do_run(1, 0, 1'b0, 5);

        // Full depth with three-cycle stalls after each accept.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < TM; i++) idle_write(1'b0, k, i, $urandom);
            for (int j = 0; j < TN; j++) idle_write(1'b1, k, j, $urandom);
        end
        do_run(4, 2, 1'b0, 2);

        // Rejected lengths.
        bad_start(0);
        bad_start(TK + 1);

        // Busy-time write to A[0][0] must not land; the next run shows the old word.
        idle_write(1'b0, 0, 0, 32'h12345678);
        do_run(3, 1, 1'b0, 1);
        do_run(2, 0, 1'b0, 0);

        // Randomised runs, including out-of-range writes and same-cycle write+start.
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(2, 12))
                idle_write($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 7), $urandom);
            do_run($urandom_range(1, TK), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 6));
        end
        do_run(TK, 1, 1'b0, 3);

        // Reset while presenting k=2.
        ready_mode = 0;
        for (int k = 0; k < 5; k++) idle_write(1'b0, k, 1, 32'hA5A50000 + 32'(k));
        start = 1'b1;
        k_len = TKLW'(5);
        for (int k = 0; k < 5; k++) exp_q.push_back('{model_a(k), model_b(k), k == 0, k == 4});
        tick();
        start = 1'b0;
        while (exp_q.size() > 3) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_valid", 256'(step_valid), 256'(0));
        check("mid_rst_tags", 256'({k_first, k_last}), 256'(0));
        check("mid_rst_a", 256'(a_row_flat), 256'(0));
        check("mid_rst_b", 256'(b_col_flat), 256'(0));
        check("mid_rst_done_err", 256'({done, err}), 256'(0));
        clear_model();
        rst = 1'b0;
        tick();
        do_run(3, 0, 1'b0, 1);

        repeat (3) tick();
        check("scoreboard_steps_empty", 256'(exp_q.size()), 256'(0));
        check("scoreboard_done_empty", 256'(done_q.size()), 256'(0));
        check("scoreboard_err_empty", 256'(err_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
